memlcd_spi_rx: RTL and testbench

SPI slave front end that feeds the memory-LCD driver's pixel FIFO write port.
- Oversamples the host SPI lines (mode 0, MSB first) in the system clock domain and assembles bytes.
- Unpacks bytes into 6-bit RGB pixels (3 bytes -> 4 pixels) and pushes them into the FIFO.
- Drives the clear-to-send flow-control pin back to the host.

---
 rtl/memlcd_spi_rx.sv | 168 ++++++++++++++++
 tb/tb_memlcd_spi_rx.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memlcd_spi_rx.sv
// SPI slave (mode 0, MSB first) that oversamples the host lines in i_clk and unpacks
// 3-byte groups into 4 six-bit pixels for the FIFO; MEMLCD_RX_UNPACKED_EN selects one pixel per byte.
module memlcd_spi_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_spi_mosi,
  input  logic             i_spi_cs_n,
  input  logic             i_spi_clk,
  output logic             o_spi_cts,
  output logic [5:0]       o_wr_data,
  output logic             o_wr_en,
  input  logic             i_wfull,
  input  logic             i_wfull_almost,
  output logic             o_overflow,
  output logic             o_frame_active,
  output logic [CNT_W-1:0] o_pixel_count
);

`ifdef MEMLCD_RX_UNPACKED_EN
  localparam int GRP_W = 8;
  localparam int NPIX  = 1;
`else
  localparam int GRP_W = 24;
  localparam int NPIX  = 4;
`endif

  // state | meaning
  // IDLE  | cs_n high, waiting for a frame
  // SHIFT | collecting bits, staging empty
  // EMIT  | staging occupied, pushing its pixels (bits keep shifting)
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_EMIT} state_t;

  state_t r_state, w_state_nxt;

  logic [SYNC_STAGES-1:0] r_sclk_sync, r_cs_sync, r_mosi_sync;
  logic                   r_sclk_prev, r_cs_prev;
  logic [4:0]             r_bit_cnt;
  logic [GRP_W-2:0]       r_group;
  logic [1:0]             r_pix_idx;
  logic [5:0]             r_wr_data;
  logic                   r_overflow, r_cts;
  logic [CNT_W-1:0]       r_pix_cnt;

  logic             w_sclk_s, w_cs_s, w_mosi_s;
  logic             w_sclk_rise, w_cs_fall, w_shift, w_grp_done;
  logic             w_occupied, w_load, w_push, w_last;
  logic [GRP_W-1:0] w_grp_word;
  logic [5:0]       w_first_pix, w_next_pix;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
      r_sclk_prev <= 1'b0;
      r_cs_prev   <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_spi_clk};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], i_spi_cs_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_spi_mosi};
      r_sclk_prev <= w_sclk_s;
      r_cs_prev   <= w_cs_s;
    end
  end

  assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk_s & ~r_sclk_prev;
  assign w_cs_fall   = ~w_cs_s & r_cs_prev;
  assign w_shift     = w_sclk_rise & ~w_cs_s;
  assign w_grp_done  = w_shift && (r_bit_cnt == 5'(GRP_W-1));
  assign w_grp_word  = {r_group, w_mosi_s};
  assign w_occupied  = (r_state == S_EMIT);
  assign w_load      = w_grp_done & ~w_occupied;
  assign w_last      = w_push && (r_pix_idx == 2'(NPIX-1));

`ifdef MEMLCD_RX_UNPACKED_EN
  assign w_first_pix = w_grp_word[5:0];
  assign w_next_pix  = w_grp_word[5:0];
`else
  logic [17:0] r_stage;

  always_ff @(posedge i_clk) begin
    if (i_reset)     r_stage <= '0;
    else if (w_load) r_stage <= w_grp_word[17:0];
  end

  assign w_first_pix = w_grp_word[23:18];

  always_comb begin
    w_next_pix = r_stage[5:0];
    case (r_pix_idx)
      2'd0:    w_next_pix = r_stage[17:12];
      2'd1:    w_next_pix = r_stage[11:6];
      default: w_next_pix = r_stage[5:0];
    endcase
  end
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_load)         w_state_nxt = S_EMIT;
        else if (w_cs_fall) w_state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        if (w_load)         w_state_nxt = S_EMIT;
        else if (w_cs_s)    w_state_nxt = S_IDLE;
      end
      S_EMIT: begin
        if (w_last)         w_state_nxt = w_cs_s ? S_IDLE : S_SHIFT;
      end
      default:              w_state_nxt = S_IDLE;
    endcase
  end

  // Push is gated by the live full flag so a held pixel never leaks while full.
  always_comb begin
    w_push = 1'b0;
    if (r_state == S_EMIT && !i_wfull && !i_reset) w_push = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_bit_cnt  <= '0;
      r_group    <= '0;
      r_pix_idx  <= '0;
      r_wr_data  <= '0;
      r_overflow <= 1'b0;
      r_pix_cnt  <= '0;
      r_cts      <= 1'b0;
    end else begin
      if (w_cs_s || w_cs_fall) r_bit_cnt <= '0;
      else if (w_shift)        r_bit_cnt <= w_grp_done ? 5'd0 : r_bit_cnt + 5'd1;
      if (w_shift) r_group <= w_grp_word[GRP_W-2:0];
      if (w_load) begin
        r_pix_idx <= '0;
        r_wr_data <= w_first_pix;
      end else if (w_push) begin
        r_pix_idx <= r_pix_idx + 2'd1;
        r_wr_data <= w_next_pix;
      end
      if (w_grp_done && w_occupied) r_overflow <= 1'b1;
      // A frame start wins over a push landing in the same cycle.
      if (w_cs_fall)   r_pix_cnt <= '0;
      else if (w_push) r_pix_cnt <= r_pix_cnt + 1'b1;
      r_cts <= ~i_wfull_almost;
    end
  end

  assign o_wr_en        = w_push;
  assign o_wr_data      = r_wr_data;
  assign o_overflow     = r_overflow;
  assign o_spi_cts      = r_cts;
  assign o_pixel_count  = r_pix_cnt;
  assign o_frame_active = ~w_cs_s;

endmodule

// File: tb/tb_memlcd_spi_rx.sv
// Self-checking bench for memlcd_spi_rx: table vectors, directed corner sequences,
// and random frames checked against an arithmetic unpacking model.
module tb_memlcd_spi_rx;
  localparam int CNT_W = 16;
`ifdef MEMLCD_RX_UNPACKED_EN
  localparam int GB  = 1;
  localparam int PPG = 1;
`else
  localparam int GB  = 3;
  localparam int PPG = 4;
`endif

  logic             clk = 1'b0;
  logic             i_reset = 1'b1;
  logic             mosi = 1'b0, cs_n = 1'b1, sclk = 1'b0;
  logic             wfull = 1'b0, walmost = 1'b0;
  logic             o_spi_cts, o_wr_en, o_overflow, o_frame_active;
  logic [5:0]       o_wr_data;
  logic [CNT_W-1:0] o_pixel_count;

  memlcd_spi_rx #(.SYNC_STAGES(2), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_spi_mosi(mosi), .i_spi_cs_n(cs_n),
    .i_spi_clk(sclk), .o_spi_cts(o_spi_cts), .o_wr_data(o_wr_data),
    .o_wr_en(o_wr_en), .i_wfull(wfull), .i_wfull_almost(walmost),
    .o_overflow(o_overflow), .o_frame_active(o_frame_active),
    .o_pixel_count(o_pixel_count)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_err = 0;
  int         bad_push = 0;
  bit         rnd_full = 1'b0;
  logic [5:0] got_q[$];
  logic [5:0] exp_q[$];

  // Sampled late in the low phase so mid-cycle input changes are seen.
  always begin
    @(negedge clk);
    #3;
    if (o_wr_en) begin
      got_q.push_back(o_wr_data);
      if (wfull) bad_push++;
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_full) wfull = ($urandom_range(0, 3) == 0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic spi_bit(input logic b);
    mosi = b;
    ticks(4);
    sclk = 1'b1;
    ticks(4);
    sclk = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) spi_bit(b[i]);
  endtask

  task automatic start_frame();
    got_q.delete();
    exp_q.delete();
    cs_n = 1'b0;
    ticks(6);
  endtask

  task automatic end_frame();
    ticks(4);
    cs_n = 1'b1;
    ticks(30);
  endtask

  task automatic cmp_pix(input string nm);
    int n;
    chk({nm, "_len"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s_pix%0d", nm, i), got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_wr_en"}, o_wr_en, 0);
    chk({nm, "_wr_data"}, o_wr_data, 0);
    chk({nm, "_cts"}, o_spi_cts, 0);
    chk({nm, "_ovf"}, o_overflow, 0);
    chk({nm, "_active"}, o_frame_active, 0);
    chk({nm, "_count"}, o_pixel_count, 0);
  endtask

  task automatic exp_packed_group(input logic [23:0] w);
    for (int k = 0; k < 4; k++) exp_q.push_back(6'((w >> (18 - 6 * k)) & 24'h3F));
  endtask

  typedef struct {
    int         nb;
    logic [7:0] b[3];
    int         np;
    logic [5:0] p[4];
  } vec_t;

  vec_t vecs[$];

  initial begin
    vec_t v;
    int   found;

`ifdef MEMLCD_RX_UNPACKED_EN
    v.nb = 2; v.b = '{8'hC5, 8'h3A, 8'h00}; v.np = 2; v.p = '{6'h05, 6'h3A, 6'h00, 6'h00}; vecs.push_back(v);
    v.nb = 3; v.b = '{8'hFF, 8'h40, 8'h81}; v.np = 3; v.p = '{6'h3F, 6'h00, 6'h01, 6'h00}; vecs.push_back(v);
`else
    v.nb = 3; v.np = 4;
    v.b = '{8'hFC, 8'h00, 8'h3F}; v.p = '{6'h3F, 6'h00, 6'h00, 6'h3F}; vecs.push_back(v);
    v.b = '{8'h04, 8'h20, 8'hC4}; v.p = '{6'h01, 6'h02, 6'h03, 6'h04}; vecs.push_back(v);
    v.b = '{8'hFF, 8'hFF, 8'hFF}; v.p = '{6'h3F, 6'h3F, 6'h3F, 6'h3F}; vecs.push_back(v);
    v.b = '{8'h00, 8'h00, 8'h00}; v.p = '{6'h00, 6'h00, 6'h00, 6'h00}; vecs.push_back(v);
    v.b = '{8'h12, 8'h34, 8'h56}; v.p = '{6'h04, 6'h23, 6'h11, 6'h16}; vecs.push_back(v);
    v.b = '{8'hA5, 8'h5A, 8'hC3}; v.p = '{6'h29, 6'h15, 6'h2B, 6'h03}; vecs.push_back(v);
`endif

    ticks(3);
    @(negedge clk);
    check_zero("reset");
    i_reset = 1'b0;
    ticks(4);

    foreach (vecs[t]) begin
      start_frame();
      for (int i = 0; i < vecs[t].nb; i++) spi_byte(vecs[t].b[i]);
      for (int i = 0; i < vecs[t].np; i++) exp_q.push_back(vecs[t].p[i]);
      end_frame();
      chk($sformatf("vec%0d_count", t), o_pixel_count, vecs[t].np);
      chk($sformatf("vec%0d_ovf", t), o_overflow, 0);
      cmp_pix($sformatf("vec%0d", t));
    end

`ifndef MEMLCD_RX_UNPACKED_EN
    // FIFO full while a group lands: pixels held, then released in order.
    wfull = 1'b1;
    start_frame();
    spi_byte(8'hFC); spi_byte(8'h00); spi_byte(8'h3F);
    ticks(14);
    chk("held_none", got_q.size(), 0);
    wfull = 1'b0;
    ticks(8);
    exp_packed_group(24'hFC003F);
    end_frame();
    chk("held_count", o_pixel_count, 4);
    cmp_pix("held");

    // Second group completes while the first is still staged.
    wfull = 1'b1;
    start_frame();
    spi_byte(8'hFC); spi_byte(8'h00); spi_byte(8'h3F);
    spi_byte(8'h04); spi_byte(8'h20); spi_byte(8'hC4);
    ticks(4);
    chk("ovf_set", o_overflow, 1);
    wfull = 1'b0;
    ticks(8);
    exp_packed_group(24'hFC003F);
    end_frame();
    chk("ovf_count", o_pixel_count, 4);
    cmp_pix("ovf");
    start_frame();
    spi_byte(8'h12); spi_byte(8'h34); spi_byte(8'h56);
    exp_packed_group(24'h123456);
    end_frame();
    chk("ovf_sticky", o_overflow, 1);
    cmp_pix("ovf_next");

    // Reset in the middle of a byte.
    start_frame();
    for (int i = 0; i < 12; i++) spi_bit(1'b1);
    i_reset = 1'b1;
    ticks(3);
    @(negedge clk);
    check_zero("midreset");
    cs_n = 1'b1;
    ticks(2);
    i_reset = 1'b0;
    ticks(4);
    start_frame();
    spi_byte(8'h04); spi_byte(8'h20); spi_byte(8'hC4);
    exp_packed_group(24'h0420C4);
    end_frame();
    chk("postreset_count", o_pixel_count, 4);
    chk("postreset_ovf", o_overflow, 0);
    cmp_pix("postreset");

    // Frame aborted after 13 bits.
    start_frame();
    for (int i = 0; i < 13; i++) spi_bit(1'b1);
    end_frame();
    chk("abort_none", got_q.size(), 0);
    start_frame();
    spi_byte(8'h04); spi_byte(8'h20); spi_byte(8'hC4);
    exp_q.push_back(6'h01); exp_q.push_back(6'h02);
    exp_q.push_back(6'h03); exp_q.push_back(6'h04);
    end_frame();
    chk("abort_count", o_pixel_count, 4);
    cmp_pix("abort");

    // Last push of a staged group coincides with the next cs_n fall.
    wfull = 1'b1;
    start_frame();
    spi_byte(8'hFC); spi_byte(8'h00); spi_byte(8'h3F);
    ticks(4);
    cs_n = 1'b1;
    ticks(10);
    wfull = 1'b0;
    ticks(3);
    wfull = 1'b1;
    ticks(2);
    chk("simul_pre_len", got_q.size(), 3);
    chk("simul_pre_count", o_pixel_count, 3);
    cs_n = 1'b0;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (o_frame_active) begin
        found = 1;
        break;
      end
    end
    chk("simul_fall_seen", found, 1);
    #1 wfull = 1'b0;
    @(posedge clk);
    #1 wfull = 1'b1;
    tick();
    @(negedge clk);
    chk("simul_count", o_pixel_count, 0);
    exp_packed_group(24'hFC003F);
    cmp_pix("simul");
    cs_n = 1'b1;
    wfull = 1'b0;
    ticks(30);

    // Clear-to-send follows almost-full, inverted, one cycle late.
    tick();
    @(negedge clk);
    chk("cts_idle", o_spi_cts, 1);
    tick();
    walmost = 1'b1;
    @(negedge clk);
    chk("cts_lag", o_spi_cts, 1);
    tick();
    @(negedge clk);
    chk("cts_low", o_spi_cts, 0);
    tick();
    walmost = 1'b0;
    @(negedge clk);
    chk("cts_lag2", o_spi_cts, 0);
    tick();
    @(negedge clk);
    chk("cts_high", o_spi_cts, 1);
`endif

    // Random frames with random full back-pressure and a discarded tail.
    rnd_full = 1'b1;
    for (int f = 0; f < 12; f++) begin
      int ng, tail;
      ng   = $urandom_range(1, 3);
      tail = $urandom_range(0, GB * 8 - 1);
      start_frame();
      for (int g = 0; g < ng; g++) begin
        logic [23:0] word;
        word = 24'($urandom);
        for (int k = GB - 1; k >= 0; k--) spi_byte(8'(word >> (8 * k)));
        if (GB == 1) exp_q.push_back(6'(word & 24'h3F));
        else         exp_packed_group(word);
      end
      for (int i = 0; i < tail; i++) spi_bit(1'($urandom));
      end_frame();
      chk($sformatf("rnd%0d_count", f), o_pixel_count, (ng * PPG) % (1 << CNT_W));
      cmp_pix($sformatf("rnd%0d", f));
    end
    rnd_full = 1'b0;
    wfull = 1'b0;
    ticks(4);

    chk("push_while_full", bad_push, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
